// File: rtl/alu_exec.sv
// Execute-stage sequencer wrapped around the 8-bit alu.
// Owns ACC and the C/Z flags; fixed 3-cycle accept-to-commit latency.
module alu_exec #(
  parameter int W = 8,
  parameter logic [W-1:0] RST_ACC = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [3:0]   req_op,
  input  logic [W-1:0] req_b,
  input  logic [2:0]   req_n,
  input  logic         req_dst,
  input  logic         acc_load,
  input  logic [W-1:0] acc_din,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [3:0]   alu_s,
  output logic [2:0]   alu_n,
  output logic         alu_cin,
  input  logic [W-1:0] alu_y,
  input  logic         alu_c,
  input  logic         alu_z,
  output logic [W-1:0] acc,
  output logic         flag_c,
  output logic         flag_z,
  output logic         wb_valid,
  output logic [W-1:0] wb_data,
  output logic         done,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    COMMIT
  } state_t;

  state_t         state;
  logic [3:0]     op_r;
  logic [W-1:0]   b_r;
  logic [2:0]     n_r;
  logic           dst_r;
  logic [W-1:0]   y_r;
  logic           c_r;
  logic           z_r;
  logic           upd_c;
  logic           upd_z;

  assign req_ready = (state == IDLE) && !acc_load;
  assign busy      = (state != IDLE);

  assign alu_a   = acc;
  assign alu_b   = b_r;
  assign alu_s   = op_r;
  assign alu_n   = n_r;
  assign alu_cin = flag_c;

  // Which flags the latched op is allowed to touch at commit.
  always_comb begin
    upd_c = 1'b0;
    upd_z = 1'b0;
    unique case (1'b1)
      (op_r inside {[4'd0:4'd4], 4'd12, 4'd13}): begin
        upd_z = 1'b1;
      end
      (op_r inside {4'd5, 4'd6, [4'd8:4'd11]}): begin
        upd_z = 1'b1;
        upd_c = 1'b1;
      end
      default: begin
        upd_c = 1'b0;
        upd_z = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= RST_ACC;
      flag_c   <= 1'b0;
      flag_z   <= 1'b0;
      wb_valid <= 1'b0;
      wb_data  <= '0;
      done     <= 1'b0;
      op_r     <= '0;
      b_r      <= '0;
      n_r      <= '0;
      dst_r    <= 1'b0;
      y_r      <= '0;
      c_r      <= 1'b0;
      z_r      <= 1'b0;
    end else begin
      done     <= 1'b0;
      wb_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (acc_load) begin
            acc <= acc_din;
          end else if (req_valid) begin
            op_r  <= req_op;
            b_r   <= req_b;
            n_r   <= req_n;
            dst_r <= req_dst;
            state <= EXEC;
          end
        end
        EXEC: begin
          y_r   <= alu_y;
          c_r   <= alu_c;
          z_r   <= alu_z;
          state <= COMMIT;
        end
        COMMIT: begin
          if (dst_r) begin
            wb_data  <= y_r;
            wb_valid <= 1'b1;
          end else begin
            acc <= y_r;
          end
          if (upd_z) flag_z <= z_r;
          if (upd_c) flag_c <= c_r;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec with a behavioural alu model on the ALU port.
// Table vectors plus hand sequences for reset, carry-in, contention.
module tb_alu_exec;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_op;
  logic [7:0] req_b;
  logic [2:0] req_n;
  logic       req_dst;
  logic       acc_load;
  logic [7:0] acc_din;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_s;
  logic [2:0] alu_n;
  logic       alu_cin;
  logic [7:0] alu_y;
  logic       alu_c;
  logic       alu_z;
  logic [7:0] acc;
  logic       flag_c;
  logic       flag_z;
  logic       wb_valid;
  logic [7:0] wb_data;
  logic       done;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_exec #(.W(8), .RST_ACC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_b(req_b), .req_n(req_n),
    .req_dst(req_dst), .acc_load(acc_load), .acc_din(acc_din),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
    .alu_n(alu_n), .alu_cin(alu_cin),
    .alu_y(alu_y), .alu_c(alu_c), .alu_z(alu_z),
    .acc(acc), .flag_c(flag_c), .flag_z(flag_z),
    .wb_valid(wb_valid), .wb_data(wb_data),
    .done(done), .busy(busy)
  );

  // Behavioural stand-in for the combinational alu.
  logic [8:0] t;
  always_comb begin
    t = 9'd0;
    case (alu_s)
      4'd0:  t = {1'b0, alu_a & alu_b};
      4'd1:  t = {1'b0, alu_a | alu_b};
      4'd2:  t = {1'b0, alu_a ^ alu_b};
      4'd3:  t = {1'b0, ~alu_a};
      4'd4:  t = {1'b0, alu_b};
      4'd5:  t = {1'b0, alu_a} + {1'b0, alu_b};
      4'd6:  t = {1'b0, alu_a} - {1'b0, alu_b};
      4'd7:  t = {1'b0, alu_a[3:0], alu_a[7:4]};
      4'd8:  t = {alu_a, 1'b0};
      4'd9:  t = {alu_a[0], 1'b0, alu_a[7:1]};
      4'd10: t = {alu_a, alu_cin};
      4'd11: t = {alu_a[0], alu_cin, alu_a[7:1]};
      4'd12: t = {1'b0, alu_a} + 9'd1;
      4'd13: t = {1'b0, alu_a} - 9'd1;
      4'd14: t = {1'b0, alu_b & ~(8'd1 << alu_n)};
      default: t = {1'b0, alu_b | (8'd1 << alu_n)};
    endcase
    alu_y = t[7:0];
    alu_c = t[8];
    alu_z = (t[7:0] == 8'd0);
  end

  typedef struct {
    logic       ld;
    logic [7:0] din;
    logic [3:0] op;
    logic [7:0] b;
    logic [2:0] n;
    logic       dst;
    logic [7:0] acc;
    logic       c;
    logic       z;
    logic       wbv;
    logic [7:0] wb;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    acc_load = 1'b1;
    acc_din  = v;
    step();
    acc_load = 1'b0;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    string p;
    v = tbl[i];
    p = $sformatf("v%0d", i);
    if (v.ld) load(v.din);
    req_op    = v.op;
    req_b     = v.b;
    req_n     = v.n;
    req_dst   = v.dst;
    req_valid = 1'b1;
    #1;
    chk({p, " ready"}, req_ready, 1);
    step();
    req_valid = 1'b0;
    chk({p, " busy_ex"}, busy, 1);
    chk({p, " done_ex"}, done, 0);
    step();
    chk({p, " done_cm"}, done, 0);
    step();
    chk({p, " done"}, done, 1);
    chk({p, " wbv"}, wb_valid, v.wbv);
    chk({p, " ready_d"}, req_ready, 1);
    chk({p, " acc"}, acc, v.acc);
    chk({p, " c"}, flag_c, v.c);
    chk({p, " z"}, flag_z, v.z);
    chk({p, " wb"}, wb_data, v.wb);
    step();
    chk({p, " done_off"}, done, 0);
    chk({p, " wbv_off"}, wb_valid, 0);
  endtask

  logic [7:0] c_acc  [7];
  logic       c_done [7];
  logic       c_busy [7];

  initial begin
    tbl[0]  = '{1'b1, 8'h0F, 4'd5,  8'h61, 3'd0, 1'b0, 8'h70, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 8'h0F, 4'd5,  8'hF1, 3'd0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[2]  = '{1'b1, 8'hF0, 4'd0,  8'hFF, 3'd0, 1'b0, 8'hF0, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[3]  = '{1'b1, 8'h01, 4'd6,  8'h01, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[4]  = '{1'b1, 8'h3C, 4'd7,  8'h00, 3'd0, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[5]  = '{1'b1, 8'h96, 4'd15, 8'h00, 3'd5, 1'b1, 8'h96, 1'b0, 1'b1, 1'b1, 8'h20};
    tbl[6]  = '{1'b1, 8'hFF, 4'd12, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h20};
    tbl[7]  = '{1'b1, 8'h00, 4'd6,  8'h01, 3'd0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h20};
    tbl[8]  = '{1'b1, 8'h10, 4'd5,  8'h20, 3'd0, 1'b1, 8'h10, 1'b0, 1'b0, 1'b1, 8'h30};
    tbl[9]  = '{1'b1, 8'h00, 4'd14, 8'hFF, 3'd0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'hFE};
    tbl[10] = '{1'b1, 8'h81, 4'd8,  8'h00, 3'd0, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0, 8'hFE};

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = 4'd0;
    req_b     = 8'd0;
    req_n     = 3'd0;
    req_dst   = 1'b0;
    acc_load  = 1'b0;
    acc_din   = 8'd0;
    #12;
    chk("rst acc", acc, 8'h00);
    chk("rst c", flag_c, 0);
    chk("rst z", flag_z, 0);
    chk("rst done", done, 0);
    chk("rst wbv", wb_valid, 0);
    chk("rst wb", wb_data, 8'h00);
    chk("rst ready", req_ready, 1);
    chk("rst busy", busy, 0);
    rst_n = 1'b1;
    step();

    // Reset while an add is in EXEC: the op must vanish.
    load(8'h0F);
    req_op    = 4'd5;
    req_b     = 8'h61;
    req_dst   = 1'b0;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    chk("mid busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid acc", acc, 8'h00);
    chk("mid busy_r", busy, 0);
    for (int k = 0; k < 2; k++) begin
      step();
      chk($sformatf("mid done_r%0d", k), done, 0);
    end
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
    chk("mid ready", req_ready, 1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("mid done_a%0d", k), done, 0);
      chk($sformatf("mid acc_a%0d", k), acc, 8'h00);
    end
    chk("mid c", flag_c, 0);
    chk("mid z", flag_z, 0);

    for (int i = 0; i < 11; i++) run_vec(i);

    // Carry flag from the last shift must reach alu_cin in EXEC.
    req_op    = 4'd9;
    req_b     = 8'h00;
    req_dst   = 1'b0;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    chk("shr cin", alu_cin, 1);
    chk("shr s", alu_s, 4'd9);
    chk("shr a", alu_a, 8'h02);
    step();
    step();
    chk("shr done", done, 1);
    chk("shr acc", acc, 8'h01);
    chk("shr c", flag_c, 0);
    chk("shr z", flag_z, 0);
    step();

    // acc_load and req_valid together, then req_valid held high.
    c_acc  = '{8'h55, 8'h55, 8'h56, 8'h56, 8'h56, 8'h57, 8'h57};
    c_done = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    c_busy = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    acc_load  = 1'b1;
    acc_din   = 8'h55;
    req_op    = 4'd5;
    req_b     = 8'h01;
    req_valid = 1'b1;
    #1;
    chk("con ready_ld", req_ready, 0);
    step();
    chk("con acc_ld", acc, 8'h55);
    chk("con busy_ld", busy, 0);
    acc_load = 1'b0;
    #1;
    chk("con ready", req_ready, 1);
    for (int k = 0; k < 7; k++) begin
      step();
      if (k == 5) req_valid = 1'b0;
      chk($sformatf("con acc%0d", k), acc, c_acc[k]);
      chk($sformatf("con done%0d", k), done, c_done[k]);
      chk($sformatf("con busy%0d", k), busy, c_busy[k]);
    end
    chk("con c", flag_c, 0);
    chk("con z", flag_z, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
